// File: rtl/wb_status_bank_pkg.sv
// Shared constants and helpers for the Wishbone read-only status bank.
// The CHG word sits immediately after the last STATUS word.
package wb_status_bank_pkg;

    localparam int CHG_IDX_OFFSET = 0;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2
    } resp_t;

    // Word-address bits needed to reach STATUS[0..n_regs-1] plus the CHG word.
    function automatic int calc_adr_w(input int n_regs);
        return $clog2(n_regs + 1);
    endfunction

endpackage

// File: rtl/wb_status_chg_det.sv
// Per-word change detector: previous-sample register, compare, and a sticky flag.
// The flag is set on change and cleared by clr; a change in the same cycle wins.
module wb_status_chg_det #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] status_word,
    input  logic         clr,
    output logic         flag
);

    logic [W-1:0] prev_reg;
    logic         primed_reg;
    logic         flag_reg;
    logic         changed;

    // primed_reg holds off detection until prev_reg has taken a real sample,
    // so leaving reset never looks like a change.
    assign changed = primed_reg && (status_word != prev_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg   <= '0;
            primed_reg <= 1'b0;
            flag_reg   <= 1'b0;
        end else begin
            prev_reg   <= status_word;
            primed_reg <= 1'b1;
            flag_reg   <= changed | (flag_reg & ~clr);
        end
    end

    assign flag = flag_reg;

endmodule

// File: rtl/wb_status_bank.sv
// Wishbone pipelined slave exposing N_REGS read-only status words, an optional
// atomic snapshot taken on reads of word 0, and clear-on-read change flags.
module wb_status_bank
    import wb_status_bank_pkg::*;
#(
    parameter int N_REGS   = 4,
    parameter int DATA_W   = 32,
    parameter bit SNAPSHOT = 1'b1,
    parameter int ADR_W    = calc_adr_w(N_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic [ADR_W+1:2]         wb_adr_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic [DATA_W-1:0]        wb_dat_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_rty_o,
    output logic                     wb_stall_o,
    output logic [DATA_W-1:0]        wb_dat_o,
    input  logic [N_REGS*DATA_W-1:0] status_i,
    output logic                     chg_irq_o
);

    localparam int CHG_IDX = N_REGS + CHG_IDX_OFFSET;

    logic              rip_reg;
    logic              wip_reg;
    logic              rd_req;
    logic              wr_req;
    logic [ADR_W-1:0]  idx;
    logic              is_status;
    logic              is_chg;
    logic              snap_load;
    logic [N_REGS-1:0] chg_flags;
    logic [N_REGS-1:0] chg_clr;
    logic [DATA_W-1:0] status_word [N_REGS];
    logic [DATA_W-1:0] view_word   [N_REGS];
    logic [DATA_W-1:0] rd_data_next;
    resp_t             resp_next;
    logic              unused_inputs;

    // Byte selects are ignored and only the low CHG bits of write data matter.
    assign unused_inputs = ^{wb_sel_i, wb_dat_i[DATA_W-1:N_REGS]};

    assign idx       = wb_adr_i;
    assign rd_req    = wb_cyc_i & wb_stb_i & ~wb_we_i & ~rip_reg;
    assign wr_req    = wb_cyc_i & wb_stb_i &  wb_we_i & ~wip_reg;
    assign is_status = int'(idx) < N_REGS;
    assign is_chg    = int'(idx) == CHG_IDX;
    assign snap_load = rd_req & (int'(idx) == 0);

    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_word
            assign status_word[gi] = status_i[gi*DATA_W +: DATA_W];

            wb_status_chg_det #(
                .W (DATA_W)
            ) u_chg_det (
                .clk         (clk_i),
                .rst_n       (rst_n_i),
                .status_word (status_word[gi]),
                .clr         (chg_clr[gi]),
                .flag        (chg_flags[gi])
            );

            // Word 0 always reads live; it is the trigger for the snapshot.
            if (gi == 0 || !SNAPSHOT) begin : g_live
                assign view_word[gi] = status_word[gi];
            end else begin : g_shadow
                logic [DATA_W-1:0] shadow_reg;
                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        shadow_reg <= '0;
                    end else if (snap_load) begin
                        shadow_reg <= status_word[gi];
                    end
                end
                assign view_word[gi] = shadow_reg;
            end
        end
    endgenerate

    // A CHG read clears exactly the flags it returns; a CHG write is W1C.
    always_comb begin
        chg_clr = '0;
        if (rd_req && is_chg) begin
            chg_clr = chg_flags;
        end else if (wr_req && is_chg) begin
            chg_clr = wb_dat_i[N_REGS-1:0];
        end
    end

    always_comb begin
        rd_data_next = '0;
        resp_next    = RESP_NONE;
        if (rd_req || wr_req) begin
            if (is_status || is_chg) begin
                resp_next = RESP_ACK;
                if (rd_req) begin
                    if (is_chg) begin
                        rd_data_next = DATA_W'(chg_flags);
                    end else begin
                        for (int k = 0; k < N_REGS; k++) begin
                            if (int'(idx) == k) begin
                                rd_data_next = view_word[k];
                            end
                        end
                    end
                end
            end else begin
                resp_next = RESP_ERR;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rip_reg   <= 1'b0;
            wip_reg   <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            chg_irq_o <= 1'b0;
        end else begin
            wb_ack_o  <= (resp_next == RESP_ACK);
            wb_err_o  <= (resp_next == RESP_ERR);
            wb_dat_o  <= rd_data_next;
            chg_irq_o <= |chg_flags;

            // Trackers block a second request until the response has gone out.
            if (rd_req) begin
                rip_reg <= 1'b1;
            end else if (wb_ack_o || wb_err_o) begin
                rip_reg <= 1'b0;
            end

            if (wr_req) begin
                wip_reg <= 1'b1;
            end else if (wb_ack_o || wb_err_o) begin
                wip_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/wb_status_bank.md
Name: wb_status_bank

Overview:
Parametrised Wishbone classic-pipelined slave exposing N_REGS read-only status words from fabric inputs. It is the generalised successor of the fixed two-register read-only bank and adds four features:
- atomic multi-word snapshot
- per-word sticky change flags (clear-on-read)
- error response for unmapped addresses
- asynchronous reset

It sits between the Wishbone crossbar and status-producing blocks (counters, monitors).

Parameters:
N_REGS, 4, number of status words; legal range 2..16
DATA_W, 32, width of each status word and of the bus data; fixed at 32 for this generation
SNAPSHOT, 1, 1 = a read of word 0 captures all words into a shadow; 0 = every word reads live
ADR_W, clog2(N_REGS+1), word-address bits used (derived; not to be overridden)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_adr_i  in  ADR_W+1:2  word address
wb_sel_i  in  4  byte selects; ignored, all accesses are full-word
wb_we_i  in  1  write enable
wb_dat_i  in  32  write data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error acknowledge
wb_rty_o  out  1  constant 0
wb_stall_o  out  1  stall
wb_dat_o  out  32  read data
status_i  in  N_REGS*32  flat status inputs; word k occupies bits [32k+31:32k]
chg_irq_o  out  1  OR of all change flags, registered

Behaviour:
- Reset: clk_i, rst_n_i, asynchronous, active-low. Reset clears to 0: wb_ack_o, wb_err_o, wb_dat_o, chg_irq_o, rip/wip trackers, shadow registers, previous-sample registers and change flags.
- First clock after reset deassertion: the previous-sample registers load status_i with no flag update, so reset release never raises a spurious change.
- Request tracking:
  - rd_req = cyc & stb & ~we & ~rip; wr_req = cyc & stb & we & ~wip.
  - rip/wip are set on the request and cleared on the response.
- Latency:
  - Exactly one response (ack or err) in the clock after the request cycle.
  - wb_stall_o = cyc & stb & ~(ack | err).
  - No back-to-back requests are accepted without an intervening response.
- Address map (word index):
  - 0..N_REGS-1: STATUS[k]
  - N_REGS: CHG; bits [N_REGS-1:0] are change flags, upper bits read 0
  - Any other index: unmapped
- Read of STATUS[0]: returns live status_i word 0. If SNAPSHOT=1, the same clock edge loads shadow[1..N_REGS-1] from status_i as sampled in the request cycle.
- Read of STATUS[k], k>0: returns shadow[k] if SNAPSHOT=1, otherwise live word k.
- Writes to STATUS: acked and ignored.
- Change flag k: set when status_i word k differs from its previous-cycle sample.
- CHG read: returns the flags, then clears those that were returned.
  - A change detected in the same cycle as the clear keeps its flag set (set wins).
- CHG write: clears flags wherever wb_dat_i bit = 1 (W1C). Set still wins over a simultaneous clear.
- chg_irq_o: registered OR of all flags; lags the flags by one cycle.
- Unmapped read or write: wb_err_o is asserted instead of wb_ack_o, with the same one-cycle latency; wb_dat_o = 0; no side effects.
- wb_dat_o:
  - Valid only while wb_ack_o is high.
  - Driven 0 during error and idle cycles. No X is ever driven.
- Reset asserted mid-transaction: the response is dropped and the bus returns to idle. The master re-issues after reset.
- wb_cyc_i dropping while a response is pending: the response is still generated next cycle; the master ignores it.

Decomposition:
- Package wb_status_bank_pkg holds:
  - the function that computes ADR_W
  - constants for the CHG word index offset and the response-type encodings (ACK, ERR)
- One sub-module, wb_status_chg_det: one instance per word via generate, containing the previous-sample register, compare, and sticky flag with set-wins clear.
- The bus front-end and the read mux stay in the top level.

Test Plan:
- Reset, then idle; assert rst_n_i low asynchronously between clock edges -> all outputs 0 immediately; no chg_irq_o after release with status_i held constant.
- N_REGS=4, status = {0x44,0x33,0x22,0x11}; read words 0..3 -> ack one cycle after each request; data 0x11, 0x22, 0x33, 0x44; stall high only in request cycles.
- SNAPSHOT=1: read word 0; change word 2 to 0xDEAD; read word 2 -> old 0x33; read word 0 again, then word 2 -> 0xDEAD.
- Toggle word 1 once -> CHG read returns 0x2 and chg_irq_o is high; second CHG read returns 0x0; chg_irq_o falls one cycle later. Word 3 changing in the cycle of the CHG read -> bit 3 still set afterwards.
- Write CHG with 0x1 while flags = 0x3 -> flags become 0x2. Write to STATUS[1] -> ack, no effect.
- Read and write to index 5 (unmapped) -> wb_err_o pulses for one cycle one cycle after each request; wb_ack_o stays 0; wb_dat_o = 0; flags unchanged.
